// File: rtl/i2s_tx_stereo.sv
// Stereo I2S / left-justified transmitter: bclk/lrclk generation, frame
// serialisation, one-entry sample holding buffer and underrun reporting.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | divider and bit counter held at 0, all I2S outputs low
// ST_RUN   | clocks running, a new frame is loaded at every counter wrap
// ST_DRAIN | enable dropped; finish the current frame, then go idle
module i2s_tx_stereo #(
   parameter int DATA_W   = 16,
   parameter int SLOT_W   = 16,
   parameter int BCLK_DIV = 20,
   parameter int MODE     = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_left,
   input  logic [DATA_W-1:0] in_right,
   output logic              i2s_bclk,
   output logic              i2s_lrclk,
   output logic              i2s_dout,
   output logic              underrun,
   output logic [7:0]        underrun_cnt,
   output logic              busy
);
   localparam int FRAME_W = 2 * SLOT_W;
   localparam int POS_W   = $clog2(FRAME_W);
   localparam int DIV_W   = $clog2(BCLK_DIV);
   localparam int LR_LO   = (MODE == 1) ? SLOT_W : SLOT_W - 1;
   localparam int LR_HI   = (MODE == 1) ? FRAME_W - 1 : FRAME_W - 2;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_W - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic               bclk_q, bclk_d;
   logic               lrclk_q, lrclk_d;
   logic               dout_q, dout_d;
   logic [FRAME_W-1:0] img_q, img_d;
   logic               buf_full_q, buf_full_d;
   logic [DATA_W-1:0]  buf_l_q, buf_l_d;
   logic [DATA_W-1:0]  buf_r_q, buf_r_d;
   logic               underrun_q, underrun_d;
   logic [7:0]         ucnt_q, ucnt_d;

   logic               load;
   logic               shift;
   logic               xfer;
   logic [FRAME_W-1:0] frame_img;

   function automatic logic lr_of(input logic [POS_W-1:0] p);
      return (int'(p) >= LR_LO) && (int'(p) <= LR_HI);
   endfunction

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      pos_d    = pos_q;
      bclk_d   = bclk_q;
      lrclk_d  = lrclk_q;
      dout_d   = dout_q;
      img_d    = img_q;
      load     = 1'b0;
      shift    = 1'b0;

      frame_img = '0;
      frame_img[FRAME_W-1 -: DATA_W] = buf_l_q;
      frame_img[SLOT_W-1 -: DATA_W]  = buf_r_q;

      case (state_q)
         ST_IDLE: begin
            div_d   = '0;
            pos_d   = '0;
            bclk_d  = 1'b0;
            lrclk_d = 1'b0;
            dout_d  = 1'b0;
            img_d   = '0;
            if (enable) begin
               state_d = ST_RUN;
               load    = 1'b1;
            end
         end
         default: begin
            if (state_q == ST_RUN && !enable) begin
               state_d = ST_DRAIN;
            end else if (state_q == ST_DRAIN && enable) begin
               state_d = ST_RUN;
            end
            if (div_q == DIV_LAST) begin
               div_d  = '0;
               bclk_d = !bclk_q;
               // bit position only moves on the bclk falling edge
               if (bclk_q) begin
                  if (pos_q != POS_LAST) begin
                     pos_d = pos_q + POS_W'(1);
                     shift = 1'b1;
                  end else if (state_d == ST_RUN) begin
                     pos_d = '0;
                     load  = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                     pos_d   = '0;
                     lrclk_d = 1'b0;
                     dout_d  = 1'b0;
                     img_d   = '0;
                  end
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
      endcase

      if (load) begin
         img_d = buf_full_q ? frame_img : '0;
      end else if (shift) begin
         img_d = img_q << 1;
      end
      // Philips output is the bit that was current before this step
      if (load || shift) begin
         lrclk_d = lr_of(pos_d);
         dout_d  = (MODE == 1) ? img_d[FRAME_W-1] : img_q[FRAME_W-1];
      end
   end

   always_comb begin
      xfer       = in_valid && !buf_full_q;
      buf_full_d = buf_full_q;
      buf_l_d    = buf_l_q;
      buf_r_d    = buf_r_q;
      if (xfer) begin
         buf_full_d = 1'b1;
         buf_l_d    = in_left;
         buf_r_d    = in_right;
      end else if (load) begin
         buf_full_d = 1'b0;
      end
      underrun_d = load && !buf_full_q;
      ucnt_d     = (underrun_d && ucnt_q != 8'hFF) ? ucnt_q + 8'd1 : ucnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         pos_q      <= '0;
         bclk_q     <= 1'b0;
         lrclk_q    <= 1'b0;
         dout_q     <= 1'b0;
         img_q      <= '0;
         buf_full_q <= 1'b0;
         buf_l_q    <= '0;
         buf_r_q    <= '0;
         underrun_q <= 1'b0;
         ucnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         pos_q      <= pos_d;
         bclk_q     <= bclk_d;
         lrclk_q    <= lrclk_d;
         dout_q     <= dout_d;
         img_q      <= img_d;
         buf_full_q <= buf_full_d;
         buf_l_q    <= buf_l_d;
         buf_r_q    <= buf_r_d;
         underrun_q <= underrun_d;
         ucnt_q     <= ucnt_d;
      end
   end

   assign in_ready     = !buf_full_q;
   assign i2s_bclk     = bclk_q;
   assign i2s_lrclk    = lrclk_q;
   assign i2s_dout     = dout_q;
   assign underrun     = underrun_q;
   assign underrun_cnt = ucnt_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Directed bench for i2s_tx_stereo: three instances cover the default Philips
// framing, 24-in-32 left-justified framing, and a fast 8/8 Philips variant.
module tb_i2s_tx_stereo;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int tcur     = 0;

   // A: defaults (Philips, 16/16, div 20)
   logic        reset_a, en_a, vld_a, rdy_a, bclk_a, lr_a, dout_a, ur_a, busy_a;
   logic [15:0] l_a, r_a;
   logic [7:0]  ucnt_a;
   // B: left-justified, 24 in 32, div 2
   logic        reset_b, en_b, vld_b, rdy_b, bclk_b, lr_b, dout_b, ur_b, busy_b;
   logic [23:0] l_b, r_b;
   logic [7:0]  ucnt_b;
   // C: Philips, 8/8, div 2
   logic        reset_c, en_c, vld_c, rdy_c, bclk_c, lr_c, dout_c, ur_c, busy_c;
   logic [7:0]  l_c, r_c;
   logic [7:0]  ucnt_c;

   logic [7:0]  lv [0:11];
   logic [7:0]  rv [0:11];

   i2s_tx_stereo u_a (
      .clk(clk), .reset(reset_a), .enable(en_a), .in_valid(vld_a), .in_ready(rdy_a),
      .in_left(l_a), .in_right(r_a), .i2s_bclk(bclk_a), .i2s_lrclk(lr_a),
      .i2s_dout(dout_a), .underrun(ur_a), .underrun_cnt(ucnt_a), .busy(busy_a));

   i2s_tx_stereo #(.DATA_W(24), .SLOT_W(32), .BCLK_DIV(2), .MODE(1)) u_b (
      .clk(clk), .reset(reset_b), .enable(en_b), .in_valid(vld_b), .in_ready(rdy_b),
      .in_left(l_b), .in_right(r_b), .i2s_bclk(bclk_b), .i2s_lrclk(lr_b),
      .i2s_dout(dout_b), .underrun(ur_b), .underrun_cnt(ucnt_b), .busy(busy_b));

   i2s_tx_stereo #(.DATA_W(8), .SLOT_W(8), .BCLK_DIV(2), .MODE(0)) u_c (
      .clk(clk), .reset(reset_c), .enable(en_c), .in_valid(vld_c), .in_ready(rdy_c),
      .in_left(l_c), .in_right(r_c), .i2s_bclk(bclk_c), .i2s_lrclk(lr_c),
      .i2s_dout(dout_c), .underrun(ur_c), .underrun_cnt(ucnt_c), .busy(busy_c));

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // advance to negedge number 'target' counted from the frame-entry edge
   task automatic adv(input int target);
      while (tcur < target) begin
         @(negedge clk);
         tcur++;
      end
   endtask

   task automatic test_reset();
      reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
      en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
      vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
      l_a = '0; r_a = '0; l_b = '0; r_b = '0; l_c = '0; r_c = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bclk_a, lr_a, dout_a, ur_a, busy_a, rdy_a} !== 6'b000001) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=000001", {bclk_a, lr_a, dout_a, ur_a, busy_a, rdy_a});
      end
      checks++;
      if (ucnt_a !== 8'd0) begin
         failures++;
         $display("FAIL reset_ucnt got=%0d exp=0", ucnt_a);
      end
      reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
      repeat (50) @(negedge clk);
      checks++;
      if ({bclk_a, busy_a, bclk_c, busy_c} !== 4'b0000) begin
         failures++;
         $display("FAIL idle_quiet got=%b exp=0000", {bclk_a, busy_a, bclk_c, busy_c});
      end
   endtask

   task automatic test_philips();
      logic [31:0] obs_d, obs_lr;
      int bmis, urs;
      logic ur_load, lr_next;
      logic [7:0] ucnt_next;
      obs_d = '0; obs_lr = '0; bmis = 0; urs = 0; ur_load = 1'b0; lr_next = 1'b1; ucnt_next = '0;
      l_a = 16'h8001; r_a = 16'h7FFE; vld_a = 1'b1;
      @(negedge clk);
      checks++;
      if (rdy_a !== 1'b0) begin
         failures++;
         $display("FAIL preload_ready got=%b exp=0", rdy_a);
      end
      l_a = 16'h1234; r_a = 16'h5678;   // must be ignored while full
      @(negedge clk);
      vld_a = 1'b0;
      en_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tcur = 0;
      checks++;
      if ({rdy_a, busy_a} !== 2'b11) begin
         failures++;
         $display("FAIL entry_ready_busy got=%b exp=11", {rdy_a, busy_a});
      end
      for (int t = 0; t <= 1290; t++) begin
         adv(t);
         if (t < 1280) begin
            if (bclk_a !== 1'((t / 20) % 2)) bmis++;
            if (ur_a) urs++;
            if (t % 40 == 10) begin
               obs_d[31 - t / 40]  = dout_a;
               obs_lr[31 - t / 40] = lr_a;
            end
         end
         if (t == 1280) ur_load = ur_a;
         if (t == 1290) begin
            lr_next   = lr_a;
            ucnt_next = ucnt_a;
         end
      end
      checks++;
      if (bmis != 0) begin
         failures++;
         $display("FAIL bclk_wave mismatching_samples=%0d exp=0", bmis);
      end
      checks++;
      if (obs_lr !== 32'h0001FFFE) begin
         failures++;
         $display("FAIL philips_lrclk got=%h exp=0001fffe", obs_lr);
      end
      checks++;
      if (obs_d !== 32'h4000BFFF) begin
         failures++;
         $display("FAIL philips_dout got=%h exp=4000bfff", obs_d);
      end
      checks++;
      if (urs != 0) begin
         failures++;
         $display("FAIL philips_no_underrun got=%0d exp=0", urs);
      end
      checks++;
      if ({ur_load, lr_next, ucnt_next} !== {1'b1, 1'b0, 8'd1}) begin
         failures++;
         $display("FAIL second_frame_underrun got=%b/%b/%0d exp=1/0/1", ur_load, lr_next, ucnt_next);
      end
      en_a = 1'b0;
   endtask

   task automatic test_lj();
      logic [63:0] obs_d, obs_lr;
      obs_d = '0; obs_lr = '0;
      l_b = 24'hABCDEF; r_b = 24'h123456; vld_b = 1'b1;
      @(negedge clk);
      vld_b = 1'b0;
      en_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tcur = 0;
      for (int p = 0; p < 64; p++) begin
         adv(4 * p + 1);
         obs_d[63 - p]  = dout_b;
         obs_lr[63 - p] = lr_b;
      end
      en_b = 1'b0;
      checks++;
      if (obs_d[63:32] !== 32'hABCDEF00) begin
         failures++;
         $display("FAIL lj_left_slot got=%h exp=abcdef00", obs_d[63:32]);
      end
      checks++;
      if (obs_d[31:0] !== 32'h12345600) begin
         failures++;
         $display("FAIL lj_right_slot got=%h exp=12345600", obs_d[31:0]);
      end
      checks++;
      if (obs_lr !== 64'h00000000FFFFFFFF) begin
         failures++;
         $display("FAIL lj_lrclk got=%h exp=00000000ffffffff", obs_lr);
      end
      checks++;
      if (ucnt_b !== 8'd0) begin
         failures++;
         $display("FAIL lj_no_underrun got=%0d exp=0", ucnt_b);
      end
   endtask

   task automatic test_underrun_sat();
      int urs, ones;
      urs = 0; ones = 0;
      en_c = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tcur = 0;
      for (int t = 0; t < 640; t++) begin
         adv(t);
         if (ur_c) urs++;
         if (dout_c) ones++;
      end
      checks++;
      if (urs != 10) begin
         failures++;
         $display("FAIL underrun_pulses got=%0d exp=10", urs);
      end
      checks++;
      if (ones != 0) begin
         failures++;
         $display("FAIL underrun_dout_zero ones=%0d exp=0", ones);
      end
      checks++;
      if (ucnt_c !== 8'd10) begin
         failures++;
         $display("FAIL underrun_cnt_10 got=%0d exp=10", ucnt_c);
      end
      adv(253 * 64 + 1);
      checks++;
      if (ucnt_c !== 8'd254) begin
         failures++;
         $display("FAIL underrun_cnt_254 got=%0d exp=254", ucnt_c);
      end
      adv(300 * 64);
      checks++;
      if (ur_c !== 1'b1) begin
         failures++;
         $display("FAIL underrun_pulse_saturated got=%b exp=1", ur_c);
      end
      adv(300 * 64 + 10);
      checks++;
      if (ucnt_c !== 8'd255) begin
         failures++;
         $display("FAIL underrun_cnt_sat got=%0d exp=255", ucnt_c);
      end
      en_c = 1'b0;
      reset_c = 1'b1;
      @(negedge clk);
      reset_c = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [15:0] phil [0:10];
      logic [15:0] lrf0, obs;
      int idx, rdy_bad, urs;
      logic pend;
      idx = 0; rdy_bad = 0; urs = 0; pend = 1'b0; lrf0 = '0;
      for (int k = 0; k < 12; k++) begin
         lv[k] = 8'(129 + k * 19);
         rv[k] = 8'(75 + k * 41);
      end
      for (int k = 0; k < 11; k++) phil[k] = '0;
      l_c = lv[0]; r_c = rv[0]; vld_c = 1'b1;
      @(negedge clk);
      idx = 1; l_c = lv[1]; r_c = rv[1];
      en_c = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tcur = 0;
      for (int t = 0; t < 704; t++) begin
         adv(t);
         if (pend) begin
            if (idx < 11) begin
               idx++;
               l_c = lv[idx];
               r_c = rv[idx];
            end else begin
               vld_c = 1'b0;
            end
         end
         if (rdy_c !== 1'((t % 64) == 0)) rdy_bad++;
         if (ur_c) urs++;
         if ((t % 64) % 4 == 1) begin
            phil[t / 64][(t % 64) / 4] = dout_c;
            if (t < 64) lrf0[15 - t / 4] = lr_c;
         end
         pend = rdy_c && vld_c;
      end
      en_c = 1'b0;
      vld_c = 1'b0;
      checks++;
      if (rdy_bad != 0) begin
         failures++;
         $display("FAIL b2b_ready_pattern bad_samples=%0d exp=0", rdy_bad);
      end
      checks++;
      if (urs != 0) begin
         failures++;
         $display("FAIL b2b_no_underrun got=%0d exp=0", urs);
      end
      checks++;
      if (lrf0 !== 16'h01FE) begin
         failures++;
         $display("FAIL b2b_lrclk got=%h exp=01fe", lrf0);
      end
      for (int k = 0; k < 10; k++) begin
         obs = '0;
         for (int j = 0; j < 15; j++) obs[15 - j] = phil[k][j + 1];
         obs[0] = phil[k + 1][0];
         checks++;
         if (obs !== {lv[k], rv[k]}) begin
            failures++;
            $display("FAIL b2b_frame%0d got=%h exp=%h", k, obs, {lv[k], rv[k]});
         end
      end
      reset_c = 1'b1;
      @(negedge clk);
      reset_c = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_drain();
      l_c = 8'hFF; r_c = 8'h01; vld_c = 1'b1;
      @(negedge clk);
      vld_c = 1'b0;
      en_c = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tcur = 0;
      adv(21);
      en_c = 1'b0;
      adv(41);
      checks++;
      if (busy_c !== 1'b1) begin
         failures++;
         $display("FAIL drain_busy got=%b exp=1", busy_c);
      end
      adv(57);
      checks++;
      if (lr_c !== 1'b1) begin
         failures++;
         $display("FAIL drain_lrclk_pos14 got=%b exp=1", lr_c);
      end
      adv(62);
      checks++;
      if (bclk_c !== 1'b1) begin
         failures++;
         $display("FAIL drain_bclk_pos15 got=%b exp=1", bclk_c);
      end
      adv(64);
      checks++;
      if ({busy_c, bclk_c, lr_c, dout_c} !== 4'b0000) begin
         failures++;
         $display("FAIL drain_to_idle got=%b exp=0000", {busy_c, bclk_c, lr_c, dout_c});
      end
      adv(80);
      checks++;
      if ({busy_c, bclk_c} !== 2'b00) begin
         failures++;
         $display("FAIL drain_stays_idle got=%b exp=00", {busy_c, bclk_c});
      end
      en_c = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tcur = 0;
      adv(21);
      en_c = 1'b0;
      adv(41);
      en_c = 1'b1;
      adv(64);
      checks++;
      if ({busy_c, ur_c} !== 2'b11) begin
         failures++;
         $display("FAIL reenable_wrap_load got=%b exp=11", {busy_c, ur_c});
      end
      adv(66);
      checks++;
      if ({bclk_c, lr_c} !== 2'b10) begin
         failures++;
         $display("FAIL reenable_no_gap got=%b exp=10", {bclk_c, lr_c});
      end
      en_c = 1'b0;
   endtask

   task automatic test_reset_midframe();
      reset_a = 1'b1;
      @(negedge clk);
      reset_a = 1'b0;
      en_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tcur = 0;
      adv(825);
      checks++;
      if ({bclk_a, lr_a, busy_a, ucnt_a} !== {3'b111, 8'd1}) begin
         failures++;
         $display("FAIL midframe_pre got=%b/%0d exp=111/1", {bclk_a, lr_a, busy_a}, ucnt_a);
      end
      #1 reset_a = 1'b1;
      #1;
      checks++;
      if ({bclk_a, lr_a, dout_a, ur_a, busy_a, rdy_a} !== 6'b000001) begin
         failures++;
         $display("FAIL midframe_reset got=%b exp=000001", {bclk_a, lr_a, dout_a, ur_a, busy_a, rdy_a});
      end
      checks++;
      if (ucnt_a !== 8'd0) begin
         failures++;
         $display("FAIL midframe_reset_ucnt got=%0d exp=0", ucnt_a);
      end
      @(negedge clk);
      reset_a = 1'b0;
      @(posedge clk);
      @(negedge clk);
      tcur = 0;
      checks++;
      if ({bclk_a, lr_a, busy_a, ur_a} !== 4'b0011) begin
         failures++;
         $display("FAIL restart_pos0 got=%b exp=0011", {bclk_a, lr_a, busy_a, ur_a});
      end
      adv(19);
      checks++;
      if (bclk_a !== 1'b0) begin
         failures++;
         $display("FAIL restart_bclk_low got=%b exp=0", bclk_a);
      end
      adv(20);
      checks++;
      if (bclk_a !== 1'b1) begin
         failures++;
         $display("FAIL restart_bclk_rise got=%b exp=1", bclk_a);
      end
      adv(570);
      checks++;
      if (lr_a !== 1'b0) begin
         failures++;
         $display("FAIL restart_lrclk_pos14 got=%b exp=0", lr_a);
      end
      adv(610);
      checks++;
      if (lr_a !== 1'b1) begin
         failures++;
         $display("FAIL restart_lrclk_pos15 got=%b exp=1", lr_a);
      end
      en_a = 1'b0;
   endtask

   initial begin
      test_reset();
      test_philips();
      test_lj();
      test_underrun_sat();
      test_back_to_back();
      test_drain();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2s_tx_stereo.md
Name: i2s_tx_stereo

Overview:
- Parametrised stereo I2S transmitter; successor to the left-only serialiser in i2s_top.
- Generates bclk/lrclk from the 44 MHz system clock and serialises left/right samples of configurable width into configurable slot width.
- Supports Philips I2S and left-justified framing.
- Accepts samples through a valid/ready handshake with a one-entry holding buffer, and reports underruns.

Parameters:
- DATA_W, 16, sample width per channel; legal range 8..32.
- SLOT_W, 16, bclk cycles per channel slot; must be >= DATA_W. Frame = 2*SLOT_W bclk.
- BCLK_DIV, 20, system clocks per bclk half-period; must be >= 2.
- MODE, 0, 0 = Philips I2S (data delayed 1 bclk after lrclk edge); 1 = left-justified.

Ports:
- clk  in  1  system clock (44 MHz)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run request
- in_valid  in  1  sample pair valid
- in_ready  out  1  holding buffer empty
- in_left  in  DATA_W  left sample, two's complement
- in_right  in  DATA_W  right sample, two's complement
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select; 0 = left, 1 = right
- i2s_dout  out  1  serial data, MSB first
- underrun  out  1  one-clk pulse at a frame load with empty buffer
- underrun_cnt  out  8  saturating underrun count
- busy  out  1  high in RUN and DRAIN

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: i2s_bclk=0, i2s_lrclk=0, i2s_dout=0, in_ready=1, underrun=0, underrun_cnt=0, busy=0. Reset also sets FSM=IDLE, buffer empty, Philips delay flop 0.
- Reset asserted mid-frame aborts immediately; no partial frame completes.
- FSM states:
  - IDLE: divider and bit counter held at 0; all I2S outputs at 0.
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0; sampled every cycle.
  - DRAIN -> IDLE at the end of the current frame (bit counter wrap). enable re-asserting in DRAIN returns to RUN without a gap.
- Divider: counts 0..BCLK_DIV-1. At terminal count, bclk toggles. bclk period = 2*BCLK_DIV clk; first rising edge occurs BCLK_DIV clk after RUN entry.
- Bit counter:
  - Range 0..2*SLOT_W-1.
  - Advances on each bclk falling edge.
  - dout and lrclk change only on falling edges, and on the RUN-entry cycle (position 0).
- Frame load: occurs at position 0 (RUN entry, or counter wrap while staying in RUN).
  - Frame image (LJ order) = {left, (SLOT_W-DATA_W) zeros, right, (SLOT_W-DATA_W) zeros}.
  - Source is the holding buffer if full; the buffer is then emptied.
  - If the buffer is empty: image is all zeros, underrun pulses 1 clk, and underrun_cnt increments, saturating at 255.
- MODE=1 (left-justified):
  - lrclk = (pos >= SLOT_W).
  - dout = image bit at pos.
- MODE=0 (Philips):
  - lrclk = 1 for pos in SLOT_W-1..2*SLOT_W-2; else 0.
  - dout = previous position's LJ bit via a 1-bit delay flop. Position 0 carries the last bit of the prior frame (0 on first frame).
  - With SLOT_W=DATA_W, the right LSB lands at pos 0 of the next frame.
- Handshake:
  - in_ready = !buffer_full.
  - Transfer when in_valid && in_ready; in_left and in_right are captured together.
  - A transfer on the same clk as an underrun load fills the buffer for the next frame; there is no bypass.
  - in_valid while in_ready=0 is ignored; no capture.
  - Transfers are accepted in IDLE as well, so a sample can be preloaded.
- Sample rate = 44 MHz / (4*BCLK_DIV*SLOT_W). Defaults give 34.375 kHz.

Test Plan:
- Defaults, preload L=0x8001 R=0x7FFE, enable=1 -> bclk period 40 clk, frame 1280 clk. lrclk low for pos 31,0..14 and high for pos 15..30. Left bits 1000...0001 appear at pos 1..16; no underrun.
- MODE=1, DATA_W=24, SLOT_W=32, L=0xABCDEF -> MSB at pos 0 with lrclk=0. Bits 24..31 are 0. Right MSB at pos 32 with lrclk=1.
- Enable with no sample loaded -> underrun pulses once per frame and dout is all 0. After 300 frames, underrun_cnt saturates at 255.
- Supply samples every frame with in_valid held high -> in_ready drops after each capture and rises one clk after each load. No underrun over 10 frames; output order matches input.
- Deassert enable at pos 5 -> frame completes through pos 31, then IDLE with outputs 0 and busy=0. Re-enable in DRAIN -> next frame starts immediately at wrap.
- Assert reset at pos 20 of a frame -> all outputs read reset values in the same cycle. After release plus enable, framing restarts at pos 0.
